// File: rtl/irq_pkg.sv
// Shared types, sizes and helpers for the interrupt controller.
package irq_pkg;

    localparam int NUM_SRC       = 16;
    localparam int NUM_GROUPS    = 4;
    localparam int SRC_PER_GROUP = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SELECT  = 2'd1,
        REQ     = 2'd2,
        ACKWAIT = 2'd3
    } irq_state_t;

    // Sources are grouped in fours, so the group is the upper two index bits.
    function automatic logic [1:0] srcGroup(input logic [3:0] idx);
        return idx[3:2];
    endfunction

    // Priority level assigned to the group that owns a given source.
    function automatic logic [1:0] srcLevel(input logic [7:0] pri, input logic [3:0] idx);
        logic [1:0] lvl;
        case (srcGroup(idx))
            2'd0:    lvl = pri[1:0];
            2'd1:    lvl = pri[3:2];
            2'd2:    lvl = pri[5:4];
            default: lvl = pri[7:6];
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// Picks the highest-level pending, enabled source above the CPU mask level.
module irq_priority_encoder (
    input  logic [15:0] i_act,
    input  logic [15:0] i_ena,
    input  logic [7:0]  i_pri,
    input  logic [1:0]  i_cpuLevel,
    output logic        o_valid,
    output logic [3:0]  o_winner,
    output logic [1:0]  o_level
);
    import irq_pkg::*;

    // Scan upward and only replace on a strictly higher level, so ties keep the lowest index.
    always_comb begin
        o_valid  = 1'b0;
        o_winner = 4'd0;
        o_level  = 2'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (i_act[i] && i_ena[i] && (srcLevel(i_pri, 4'(i)) > i_cpuLevel) &&
                (!o_valid || (srcLevel(i_pri, 4'(i)) > o_level))) begin
                o_valid  = 1'b1;
                o_winner = 4'(i);
                o_level  = srcLevel(i_pri, 4'(i));
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Vectored interrupt controller: latches source pulses, prioritises them by
// group level and hands one winner at a time to the CPU with req/ack.
module irq_controller #(
    parameter logic [23:0] IRQ_PRI     = 24'h000100,
    parameter logic [23:0] IRQ_ENA     = 24'h000102,
    parameter logic [23:0] IRQ_ACT     = 24'h000104,
    parameter logic [7:0]  VECTOR_BASE = 8'h03
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_ce_cpu,
    input  logic        bus_write,
    input  logic        bus_read,
    input  logic [23:0] bus_address_in,
    input  logic [7:0]  bus_data_in,
    output logic [7:0]  bus_data_out,
    input  logic [15:0] irq_src,
    input  logic [1:0]  cpu_level,
    output logic        irq_req,
    output logic [7:0]  irq_vector,
    output logic [1:0]  irq_level,
    input  logic        irq_ack
);
    import irq_pkg::*;

    localparam logic [23:0] ADDR_ENA_HI = IRQ_ENA + 24'd1;
    localparam logic [23:0] ADDR_ACT_HI = IRQ_ACT + 24'd1;

    logic [7:0]  r_pri;
    logic [15:0] r_ena;
    logic [15:0] r_act;
    irq_state_t  r_state;
    irq_state_t  w_nextState;
    logic [3:0]  r_winIdx;
    logic [1:0]  r_winLevel;

    logic        w_encValid;
    logic [3:0]  w_encIdx;
    logic [1:0]  w_encLevel;
    logic        w_latch;
    logic        w_ackClear;
    logic        w_latchedCand;
    logic [15:0] w_w1cMask;
    logic [15:0] w_ackMask;
    logic        w_unusedRead;

    // Reads have no side effects, so the read strobe carries no information here.
    assign w_unusedRead = bus_read;

    irq_priority_encoder u_encoder (
        .i_act      (r_act),
        .i_ena      (r_ena),
        .i_pri      (r_pri),
        .i_cpuLevel (cpu_level),
        .o_valid    (w_encValid),
        .o_winner   (w_encIdx),
        .o_level    (w_encLevel)
    );

    assign w_latchedCand = r_act[r_winIdx] & r_ena[r_winIdx] &
                           (srcLevel(r_pri, r_winIdx) > cpu_level);

    assign w_ackMask = w_ackClear ? (16'h0001 << r_winIdx) : 16'h0000;

    // Write-1-to-clear mask from a bus write to either active-flag byte.
    always_comb begin
        w_w1cMask = 16'h0000;
        if (bus_write) begin
            if (bus_address_in == IRQ_ACT) begin
                w_w1cMask = {8'h00, bus_data_in};
            end else if (bus_address_in == ADDR_ACT_HI) begin
                w_w1cMask = {bus_data_in, 8'h00};
            end
        end
    end

    // Priority and enable registers are plain read/write storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pri <= 8'h00;
            r_ena <= 16'h0000;
        end else if (clk_ce_cpu && bus_write) begin
            if (bus_address_in == IRQ_PRI) begin
                r_pri <= bus_data_in;
            end else if (bus_address_in == IRQ_ENA) begin
                r_ena[7:0] <= bus_data_in;
            end else if (bus_address_in == ADDR_ENA_HI) begin
                r_ena[15:8] <= bus_data_in;
            end
        end
    end

    // Active flags: new pulses are OR-ed in last so a set beats any same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_act <= 16'h0000;
        end else if (clk_ce_cpu) begin
            r_act <= (r_act & ~(w_w1cMask | w_ackMask)) | irq_src;
        end
    end

    // Holds the source currently being offered to the CPU.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_winIdx   <= 4'd0;
            r_winLevel <= 2'd0;
        end else if (clk_ce_cpu && w_latch) begin
            r_winIdx   <= w_encIdx;
            r_winLevel <= w_encLevel;
        end
    end

    // Handshake state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else if (clk_ce_cpu) begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; ack is checked first so it beats cancellation and preemption.
    always_comb begin
        w_nextState = r_state;
        w_latch     = 1'b0;
        w_ackClear  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_encValid) begin
                    w_nextState = SELECT;
                    w_latch     = 1'b1;
                end
            end
            SELECT: begin
                w_nextState = REQ;
            end
            REQ: begin
                if (irq_ack) begin
                    w_nextState = ACKWAIT;
                    w_ackClear  = 1'b1;
                end else if (!w_latchedCand) begin
                    w_nextState = IDLE;
                end else if (w_encValid && (w_encLevel > r_winLevel) && (w_encIdx != r_winIdx)) begin
                    w_nextState = SELECT;
                    w_latch     = 1'b1;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // CPU-facing outputs are driven only while the request is up.
    always_comb begin
        irq_req    = 1'b0;
        irq_vector = 8'h00;
        irq_level  = 2'd0;
        if (r_state == REQ) begin
            irq_req    = 1'b1;
            irq_vector = VECTOR_BASE + {4'h0, r_winIdx};
            irq_level  = r_winLevel;
        end
    end

    // Combinational register readback.
    always_comb begin
        bus_data_out = 8'h00;
        if (bus_address_in == IRQ_PRI) begin
            bus_data_out = r_pri;
        end else if (bus_address_in == IRQ_ENA) begin
            bus_data_out = r_ena[7:0];
        end else if (bus_address_in == ADDR_ENA_HI) begin
            bus_data_out = r_ena[15:8];
        end else if (bus_address_in == IRQ_ACT) begin
            bus_data_out = r_act[7:0];
        end else if (bus_address_in == ADDR_ACT_HI) begin
            bus_data_out = r_act[15:8];
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller with hand-computed expectations.
module tb_irq_controller;

    localparam logic [23:0] A_PRI = 24'h000100;
    localparam logic [23:0] A_ENA = 24'h000102;
    localparam logic [23:0] A_ACT = 24'h000104;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk_ce_cpu = 1'b1;
    logic        bus_write = 1'b0;
    logic        bus_read = 1'b0;
    logic [23:0] bus_address_in = 24'h0;
    logic [7:0]  bus_data_in = 8'h0;
    logic [7:0]  bus_data_out;
    logic [15:0] irq_src = 16'h0;
    logic [1:0]  cpu_level = 2'd0;
    logic        irq_req;
    logic [7:0]  irq_vector;
    logic [1:0]  irq_level;
    logic        irq_ack = 1'b0;

    int checkCount = 0;
    int passCount  = 0;

    irq_controller #(
        .IRQ_PRI     (A_PRI),
        .IRQ_ENA     (A_ENA),
        .IRQ_ACT     (A_ACT),
        .VECTOR_BASE (8'h03)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .clk_ce_cpu     (clk_ce_cpu),
        .bus_write      (bus_write),
        .bus_read       (bus_read),
        .bus_address_in (bus_address_in),
        .bus_data_in    (bus_data_in),
        .bus_data_out   (bus_data_out),
        .irq_src        (irq_src),
        .cpu_level      (cpu_level),
        .irq_req        (irq_req),
        .irq_vector     (irq_vector),
        .irq_level      (irq_level),
        .irq_ack        (irq_ack)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Advance n clock edges and settle 1 time unit past the last one.
    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic busWrite(input logic [23:0] addr, input logic [7:0] data);
        bus_write      = 1'b1;
        bus_address_in = addr;
        bus_data_in    = data;
        applyStimulus(1);
        bus_write      = 1'b0;
    endtask

    task automatic busRead(input logic [23:0] addr, output logic [7:0] data);
        bus_read       = 1'b1;
        bus_address_in = addr;
        #1;
        data           = bus_data_out;
        bus_read       = 1'b0;
    endtask

    task automatic pulseSrc(input logic [15:0] mask);
        irq_src = mask;
        applyStimulus(1);
        irq_src = 16'h0;
    endtask

    task automatic ackOnce();
        irq_ack = 1'b1;
        applyStimulus(1);
        irq_ack = 1'b0;
    endtask

    task automatic checkAct(input string tag, input logic [15:0] expected);
        logic [7:0] lo;
        logic [7:0] hi;
        busRead(A_ACT, lo);
        busRead(A_ACT + 24'd1, hi);
        checkOutput(tag, {hi, lo}, expected);
    endtask

    task automatic checkReq(input string tag, input logic req, input logic [7:0] vec, input logic [1:0] lvl);
        checkOutput({tag, "_req"}, {15'h0, irq_req}, {15'h0, req});
        checkOutput({tag, "_vec"}, {8'h0, irq_vector}, {8'h0, vec});
        checkOutput({tag, "_lvl"}, {14'h0, irq_level}, {14'h0, lvl});
    endtask

    task automatic checkRegsZero(input string tag);
        logic [7:0] d;
        busRead(A_PRI, d);
        checkOutput({tag, "_pri"}, {8'h0, d}, 16'h0000);
        busRead(A_ENA, d);
        checkOutput({tag, "_enaLo"}, {8'h0, d}, 16'h0000);
        busRead(A_ENA + 24'd1, d);
        checkOutput({tag, "_enaHi"}, {8'h0, d}, 16'h0000);
        checkAct({tag, "_act"}, 16'h0000);
    endtask

    initial begin
        logic [7:0] rd;

        // Reset state
        reset = 1'b1;
        applyStimulus(2);
        reset = 1'b0;
        checkReq("reset", 1'b0, 8'h00, 2'd0);
        checkRegsZero("reset");

        // Single request on source 0, group 0 at level 3
        busWrite(A_PRI, 8'h03);
        busWrite(A_ENA, 8'h01);
        busWrite(A_ENA + 24'd1, 8'h00);
        busRead(A_PRI, rd);
        checkOutput("priReadback", {8'h0, rd}, 16'h0003);
        pulseSrc(16'h0001);
        checkReq("single_E0", 1'b0, 8'h00, 2'd0);
        applyStimulus(1);
        checkReq("single_E1", 1'b0, 8'h00, 2'd0);
        applyStimulus(1);
        checkReq("single_E2", 1'b1, 8'h03, 2'd3);
        ackOnce();
        checkReq("single_ack", 1'b0, 8'h00, 2'd0);
        checkAct("single_actCleared", 16'h0000);
        applyStimulus(1);

        // Tie-break: sources 1 and 2 at level 2
        busWrite(A_PRI, 8'h02);
        busWrite(A_ENA, 8'h06);
        pulseSrc(16'h0006);
        applyStimulus(2);
        checkReq("tie_first", 1'b1, 8'h04, 2'd2);
        ackOnce();
        checkReq("tie_ackDrop", 1'b0, 8'h00, 2'd0);
        checkAct("tie_actLeft", 16'h0004);
        applyStimulus(1);
        checkOutput("tie_gap1", {15'h0, irq_req}, 16'h0000);
        applyStimulus(1);
        checkOutput("tie_gap2", {15'h0, irq_req}, 16'h0000);
        applyStimulus(1);
        checkReq("tie_second", 1'b1, 8'h05, 2'd2);
        ackOnce();
        applyStimulus(1);

        // Masking: group 1 at level 1 hidden by cpu_level 1
        busWrite(A_PRI, 8'h04);
        busWrite(A_ENA, 8'h20);
        cpu_level = 2'd1;
        pulseSrc(16'h0020);
        applyStimulus(3);
        checkReq("mask_blocked", 1'b0, 8'h00, 2'd0);
        checkAct("mask_pending", 16'h0020);
        cpu_level = 2'd0;
        applyStimulus(2);
        checkReq("mask_released", 1'b1, 8'h08, 2'd1);
        ackOnce();
        applyStimulus(1);

        // Preemption: source 4 at level 1 pre-empted by source 12 at level 3
        busWrite(A_PRI, 8'hC4);
        busWrite(A_ENA, 8'h10);
        busWrite(A_ENA + 24'd1, 8'h10);
        pulseSrc(16'h0010);
        applyStimulus(2);
        checkReq("pre_low", 1'b1, 8'h07, 2'd1);
        pulseSrc(16'h1000);
        checkReq("pre_stillLow", 1'b1, 8'h07, 2'd1);
        applyStimulus(1);
        checkReq("pre_gap", 1'b0, 8'h00, 2'd0);
        applyStimulus(1);
        checkReq("pre_high", 1'b1, 8'h0F, 2'd3);
        ackOnce();
        checkAct("pre_actAfterAck", 16'h0010);
        applyStimulus(3);
        checkReq("pre_resume", 1'b1, 8'h07, 2'd1);

        // Cancel: W1C the latched source while requesting
        busWrite(A_ACT, 8'h10);
        checkOutput("cancel_sameEdge", {15'h0, irq_req}, 16'h0001);
        applyStimulus(1);
        checkReq("cancel_drop", 1'b0, 8'h00, 2'd0);
        checkAct("cancel_act", 16'h0000);
        applyStimulus(2);
        checkOutput("cancel_stayIdle", {15'h0, irq_req}, 16'h0000);

        // Race: set and W1C of bit 0 in the same cycle, set wins
        irq_src = 16'h0001;
        busWrite(A_ACT, 8'h01);
        irq_src = 16'h0000;
        checkAct("race_setWins", 16'h0001);
        busWrite(A_ACT, 8'h01);
        checkAct("race_cleared", 16'h0000);

        // Clock-enable low holds everything, including pending flags
        pulseSrc(16'h0010);
        clk_ce_cpu = 1'b0;
        applyStimulus(4);
        checkReq("ce_hold", 1'b0, 8'h00, 2'd0);
        checkAct("ce_actHeld", 16'h0010);
        clk_ce_cpu = 1'b1;
        applyStimulus(2);
        checkReq("ce_resume", 1'b1, 8'h07, 2'd1);

        // Reset while requesting
        reset = 1'b1;
        applyStimulus(1);
        reset = 1'b0;
        checkReq("resetReq", 1'b0, 8'h00, 2'd0);
        checkRegsZero("resetReq");
        applyStimulus(2);
        checkOutput("resetReq_quiet", {15'h0, irq_req}, 16'h0000);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
# irq_controller

Central interrupt controller between the peripheral interrupt sources (timer irq pulses, RTC, keypad, and so on) and the CPU core. It latches one-cycle interrupt pulses from 16 sources into active flags and gates them with per-source enables. It resolves priority using four 2-bit group levels, then presents a single vectored request to the CPU with a request/acknowledge handshake. It is register-mapped on the CPU bus alongside the timer blocks.

## Interface
Parameters:
- IRQ_PRI, none: bus address of the group priority register (8 bit; group g uses bits [2g+1:2g]).
- IRQ_ENA, none: bus address of the enable low byte; IRQ_ENA+1 holds the high byte.
- IRQ_ACT, none: bus address of the active-flag low byte; IRQ_ACT+1 holds the high byte.
- VECTOR_BASE, 8'h03: vector number of source 0; source i uses VECTOR_BASE+i.

Ports:
- clk, in, 1: sole clock, rising edge.
- reset, in, 1: synchronous, active-high; takes effect on any clk edge regardless of clk_ce_cpu.
- clk_ce_cpu, in, 1: qualifies every non-reset state update.
- bus_write, in, 1: write strobe.
- bus_read, in, 1: read strobe (informational only; reads have no side effects).
- bus_address_in, in, 24: bus address.
- bus_data_in, in, 8: write data.
- bus_data_out, out, 8: combinational read data; 0 for unmapped addresses.
- irq_src, in, 16: per-source event pulses, sampled on ce cycles.
- cpu_level, in, 2: current CPU interrupt mask level.
- irq_req, out, 1: request to the CPU.
- irq_vector, out, 8: vector of the pending winner; valid while irq_req is high.
- irq_level, out, 2: priority level of the winner.
- irq_ack, in, 1: CPU acceptance, one ce cycle.

## Operation
- Source i belongs to group i/4. A source is a candidate when act[i] & ena[i] & (pri[g] > cpu_level). A group priority of 0 therefore never fires.
- Winner selection: the candidate with the highest group level wins. Ties go to the lowest index.
- act[i] is set by irq_src[i]. A bus write to an IRQ_ACT byte clears every bit written as 1 (write-1-to-clear). Set wins over a same-cycle clear or ack-clear.
- IRQ_PRI and IRQ_ENA are plain read/write registers. Reads of IRQ_ACT return the raw flags.
- FSM states:
  - IDLE → SELECT when any candidate exists. On that transition, latch the winner index and level.
  - SELECT → REQ unconditionally. irq_req goes to 1 and irq_vector/irq_level are driven from the latch.
  - In REQ, the winner is re-evaluated every ce cycle:
    - irq_ack=1 → clear act[winner] and go to ACKWAIT.
    - Latched source no longer a candidate (W1C, enable cleared, priority lowered, or cpu_level raised) → IDLE, irq_req=0.
    - A different source becomes winner at a strictly higher level → SELECT, irq_req=0 for one cycle (preemption).
  - ACKWAIT → IDLE after one ce cycle. This guarantees irq_req is low for at least one cycle between requests.
- irq_ack outside REQ is ignored.

## Timing
- Reset values: pri=0, ena=0, act=0, state IDLE, irq_req=0, irq_vector=0, irq_level=0.
- Bus writes land on the ce edge where bus_write=1 and are visible to the candidate logic on the next ce cycle.
- Latency: an irq_src pulse sampled at ce edge E0 gives IDLE→SELECT at E1 and irq_req=1 after E2.
- Ack: with irq_ack at edge Ea, irq_req=0 and act cleared after Ea. The earliest next irq_req is after Ea+3 (ACKWAIT, IDLE, SELECT).
- Ack and preemption on the same edge: ack wins.
- Reset mid-request: irq_req drops on the reset edge and all flags are cleared.
- With clk_ce_cpu low, all state holds, including pending irq_src. Sources are expected to pulse only in ce cycles.

## Structure
- Package irq_pkg:
  - state enum {IDLE, SELECT, REQ, ACKWAIT};
  - NUM_SRC=16, NUM_GROUPS=4, SRC_PER_GROUP=4;
  - a function mapping a source index to its group.
- Sub-module irq_priority_encoder: combinational. Inputs are act, ena, pri and cpu_level; outputs are valid, winner index (4 bits) and level (2 bits). It is instantiated once and used for both IDLE latching and REQ re-evaluation.

## Test plan
- Single request: pri=8'h03 (group 0 at level 3), ena=16'h0001, cpu_level=0, pulse irq_src[0] → irq_req=1 two ce edges later, irq_vector=8'h03, irq_level=3. Ack → act reads 0 and irq_req=0.
- Tie-break: sources 1 and 2 pulse together, group 0 at level 2 → vector 8'h04 served first. After ack and 3 cycles, vector 8'h05 is requested.
- Masking: group 1 at level 1, cpu_level=1, pulse irq_src[5] → no request. Lower cpu_level to 0 → irq_req with vector 8'h08.
- Preemption: source 4 pending (group 1 at level 1); pulse source 12 (group 3 at level 3) in REQ → irq_req low for one cycle, then vector 8'h0F at level 3.
- Cancel/race: W1C of act bit 0 while in REQ → irq_req drops, state returns to IDLE. irq_src[0] together with a W1C of bit 0 in the same cycle → act[0] stays 1.
- Reset during REQ → all outputs 0 and registers read 0 on the next read.
